ysyx_24090003_wbu: RTL and testbench

YSYX_24090003_WBU -- requirements
Module: ysyx_24090003_WBU

---
 rtl/ysyx_24090003_wbu.sv | 161 ++++++++++++++++
 tb/tb_ysyx_24090003_wbu.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24090003_wbu.sv
// rtl/ysyx_24090003_wbu.sv - writeback unit: load extraction, rd write and commit pulse.
// Optional forwarding outputs are enabled by defining YSYX_24090003_WB_FWD_EN.
module ysyx_24090003_wbu (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_pc,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_rd_wen,
    input  logic [1:0]  i_wb_sel,
    input  logic [31:0] i_alu_res,
    input  logic [31:0] i_csr_rdata,
    input  logic [2:0]  i_ld_func,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_wdata,
    output logic        o_reg_wen,
    output logic        o_commit,
    output logic [31:0] o_commit_pc
`ifdef YSYX_24090003_WB_FWD_EN
    ,
    output logic        o_fwd_valid,
    output logic [4:0]  o_fwd_addr,
    output logic [31:0] o_fwd_data
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_e;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic        rd_wen_q, rd_wen_d;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic [31:0] alu_res_q, alu_res_d;
    logic [31:0] csr_rdata_q, csr_rdata_d;
    logic [2:0]  ld_func_q, ld_func_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic [4:0]  last_addr_q, last_addr_d;
    logic [31:0] last_wdata_q, last_wdata_d;
    logic [31:0] wr_data;
    logic        accept;

    function automatic logic [31:0] load_ext(input logic [2:0] func, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (func)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'd0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = word;
        endcase
    endfunction

    assign o_in_ready = (state_q != WAIT_MEM) && !i_rst;
    assign accept     = i_in_valid && o_in_ready;

    always_comb begin
        case (wb_sel_q)
            SEL_ALU:  wr_data = alu_res_q;
            SEL_LOAD: wr_data = ld_data_q;
            SEL_PC4:  wr_data = pc_q + 32'd4;
            default:  wr_data = csr_rdata_q;
        endcase
    end

    // Outside WRITE the register-file port shows the last written pair, not the pending one.
    assign o_commit    = (state_q == WRITE);
    assign o_reg_wen   = o_commit && rd_wen_q && (rd_addr_q != 5'd0);
    assign o_commit_pc = o_commit ? pc_q : 32'd0;
    assign o_rd_addr   = o_commit ? rd_addr_q : last_addr_q;
    assign o_rd_wdata  = o_commit ? wr_data : last_wdata_q;

`ifdef YSYX_24090003_WB_FWD_EN
    assign o_fwd_valid = o_reg_wen;
    assign o_fwd_addr  = o_rd_addr;
    assign o_fwd_data  = o_rd_wdata;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        rd_addr_d    = rd_addr_q;
        rd_wen_d     = rd_wen_q;
        wb_sel_d     = wb_sel_q;
        alu_res_d    = alu_res_q;
        csr_rdata_d  = csr_rdata_q;
        ld_func_d    = ld_func_q;
        ld_data_d    = ld_data_q;
        last_addr_d  = last_addr_q;
        last_wdata_d = last_wdata_q;
        case (state_q)
            WAIT_MEM: begin
                if (i_mem_rvalid) begin
                    ld_data_d = load_ext(ld_func_q, alu_res_q[1:0], i_mem_rdata);
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                last_addr_d  = rd_addr_q;
                last_wdata_d = wr_data;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            pc_d        = i_pc;
            rd_addr_d   = i_rd_addr;
            rd_wen_d    = i_rd_wen;
            wb_sel_d    = i_wb_sel;
            alu_res_d   = i_alu_res;
            csr_rdata_d = i_csr_rdata;
            ld_func_d   = i_ld_func;
            state_d     = (i_wb_sel == SEL_LOAD) ? WAIT_MEM : WRITE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            pc_q         <= 32'd0;
            rd_addr_q    <= 5'd0;
            rd_wen_q     <= 1'b0;
            wb_sel_q     <= 2'd0;
            alu_res_q    <= 32'd0;
            csr_rdata_q  <= 32'd0;
            ld_func_q    <= 3'd0;
            ld_data_q    <= 32'd0;
            last_addr_q  <= 5'd0;
            last_wdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            rd_addr_q    <= rd_addr_d;
            rd_wen_q     <= rd_wen_d;
            wb_sel_q     <= wb_sel_d;
            alu_res_q    <= alu_res_d;
            csr_rdata_q  <= csr_rdata_d;
            ld_func_q    <= ld_func_d;
            ld_data_q    <= ld_data_d;
            last_addr_q  <= last_addr_d;
            last_wdata_q <= last_wdata_d;
        end
    end

endmodule

// File: tb/tb_ysyx_24090003_wbu.sv
// tb/tb_ysyx_24090003_wbu.sv - directed self-checking bench for ysyx_24090003_wbu.
module tb_ysyx_24090003_wbu;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [31:0] i_pc = 32'd0;
    logic [4:0]  i_rd_addr = 5'd0;
    logic        i_rd_wen = 1'b0;
    logic [1:0]  i_wb_sel = 2'd0;
    logic [31:0] i_alu_res = 32'd0;
    logic [31:0] i_csr_rdata = 32'd0;
    logic [2:0]  i_ld_func = 3'd0;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = 32'd0;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_wdata;
    logic        o_reg_wen;
    logic        o_commit;
    logic [31:0] o_commit_pc;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_24090003_wbu dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_pc         (i_pc),
        .i_rd_addr    (i_rd_addr),
        .i_rd_wen     (i_rd_wen),
        .i_wb_sel     (i_wb_sel),
        .i_alu_res    (i_alu_res),
        .i_csr_rdata  (i_csr_rdata),
        .i_ld_func    (i_ld_func),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .o_rd_addr    (o_rd_addr),
        .o_rd_wdata   (o_rd_wdata),
        .o_reg_wen    (o_reg_wen),
        .o_commit     (o_commit),
        .o_commit_pc  (o_commit_pc)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                         input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] csr,
                         input logic [2:0] func);
        i_in_valid  = 1'b1;
        i_pc        = pc;
        i_rd_addr   = rd;
        i_rd_wen    = wen;
        i_wb_sel    = sel;
        i_alu_res   = alu;
        i_csr_rdata = csr;
        i_ld_func   = func;
    endtask

    task automatic chk_write(input string tag, input logic wen, input logic [4:0] rd,
                             input logic [31:0] data, input logic [31:0] pc);
        chk1({tag, "_commit"}, o_commit, 1'b1);
        chk1({tag, "_wen"}, o_reg_wen, wen);
        chk({tag, "_addr"}, {27'd0, o_rd_addr}, {27'd0, rd});
        chk({tag, "_data"}, o_rd_wdata, data);
        chk({tag, "_pc"}, o_commit_pc, pc);
    endtask

    // Issue a load, then return rvalid with rdata on the next cycle and check the write.
    task automatic do_load(input string tag, input logic [2:0] func, input logic [31:0] alu,
                           input logic [31:0] rdata, input logic [31:0] exp);
        issue(32'h200, 5'd9, 1'b1, 2'b01, alu, 32'd0, func);
        tick();
        i_in_valid   = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = rdata;
        tick();
        i_mem_rvalid = 1'b0;
        chk_write(tag, 1'b1, 5'd9, exp, 32'h200);
        tick();
    endtask

    initial begin
        #1;
        chk1("rst_ready", o_in_ready, 1'b0);
        tick();
        tick();
        chk1("rst_commit", o_commit, 1'b0);
        chk1("rst_wen", o_reg_wen, 1'b0);
        chk("rst_addr", {27'd0, o_rd_addr}, 32'd0);
        chk("rst_wdata", o_rd_wdata, 32'd0);
        chk("rst_pc", o_commit_pc, 32'd0);
        i_rst = 1'b0;
        #1;
        chk1("post_rst_ready", o_in_ready, 1'b1);

        // ALU op, one-cycle latency, then hold of the write port in IDLE
        issue(32'h100, 5'd5, 1'b1, 2'b00, 32'h1234, 32'd0, 3'd0);
        tick();
        i_in_valid = 1'b0;
        chk_write("alu", 1'b1, 5'd5, 32'h1234, 32'h100);
        tick();
        chk1("idle_commit", o_commit, 1'b0);
        chk1("idle_wen", o_reg_wen, 1'b0);
        chk("idle_addr_hold", {27'd0, o_rd_addr}, 32'd5);
        chk("idle_wdata_hold", o_rd_wdata, 32'h1234);

        // stray rvalid in IDLE is ignored
        i_mem_rvalid = 1'b1;
        tick();
        i_mem_rvalid = 1'b0;
        chk1("stray_rvalid_commit", o_commit, 1'b0);
        chk1("stray_rvalid_ready", o_in_ready, 1'b1);

        // LB with rvalid three cycles after accept
        issue(32'h104, 5'd6, 1'b1, 2'b01, 32'h2, 32'd0, 3'b000);
        tick();
        i_in_valid = 1'b0;
        chk1("lb_ready_c1", o_in_ready, 1'b0);
        chk1("lb_commit_c1", o_commit, 1'b0);
        tick();
        chk1("lb_ready_c2", o_in_ready, 1'b0);
        tick();
        chk1("lb_ready_c3", o_in_ready, 1'b0);
        chk("lb_wdata_hold", o_rd_wdata, 32'h1234);
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h0080_0000;
        tick();
        i_mem_rvalid = 1'b0;
        chk_write("lb", 1'b1, 5'd6, 32'hFFFF_FF80, 32'h104);
        chk1("lb_ready_write", o_in_ready, 1'b1);
        tick();

        do_load("lhu_off3", 3'b101, 32'h3, 32'hBEEF_1234, 32'h0000_BEEF);
        do_load("lw_off1", 3'b010, 32'h1, 32'hBEEF_1234, 32'hBEEF_1234);
        do_load("lh_off0", 3'b001, 32'h0, 32'h0000_8001, 32'hFFFF_8001);
        do_load("lbu_off3", 3'b100, 32'h3, 32'hBEEF_1234, 32'h0000_00BE);
        do_load("lb_off1", 3'b000, 32'h1, 32'h0000_7F00, 32'h0000_007F);
        do_load("func111", 3'b111, 32'h2, 32'h89AB_CDEF, 32'h89AB_CDEF);

        // rd=0 with PC+4 wrap
        issue(32'hFFFF_FFFC, 5'd0, 1'b1, 2'b10, 32'd0, 32'd0, 3'd0);
        tick();
        i_in_valid = 1'b0;
        chk_write("rd0_pc4", 1'b0, 5'd0, 32'h0000_0000, 32'hFFFF_FFFC);
        tick();

        // CSR source, and rd_wen=0 still commits without writing
        issue(32'h300, 5'd7, 1'b1, 2'b11, 32'h1, 32'hCAFE_F00D, 3'd0);
        tick();
        issue(32'h304, 5'd8, 1'b0, 2'b10, 32'h0, 32'h0, 3'd0);
        chk_write("csr", 1'b1, 5'd7, 32'hCAFE_F00D, 32'h300);
        tick();
        i_in_valid = 1'b0;
        chk_write("nowen", 1'b0, 5'd8, 32'h0000_0308, 32'h304);
        tick();

        // four ALU ops back to back
        for (int k = 0; k < 4; k++) begin
            issue(32'h400 + 32'(4 * k), 5'(10 + k), 1'b1, 2'b00, 32'hA000 + 32'(k), 32'd0, 3'd0);
            tick();
            chk_write($sformatf("b2b%0d", k), 1'b1, 5'(10 + k), 32'hA000 + 32'(k),
                      32'h400 + 32'(4 * k));
            chk1($sformatf("b2b%0d_ready", k), o_in_ready, 1'b1);
        end
        i_in_valid = 1'b0;
        tick();
        chk1("b2b_end_commit", o_commit, 1'b0);

        // asynchronous reset while in WRITE
        issue(32'h500, 5'd3, 1'b1, 2'b00, 32'h55, 32'd0, 3'd0);
        tick();
        i_in_valid = 1'b0;
        chk1("pre_rst_write_commit", o_commit, 1'b1);
        i_rst = 1'b1;
        #1;
        chk1("rst_write_commit", o_commit, 1'b0);
        chk1("rst_write_wen", o_reg_wen, 1'b0);
        chk("rst_write_wdata", o_rd_wdata, 32'd0);
        tick();
        i_rst = 1'b0;
        #1;

        // reset while in WAIT_MEM discards the load
        issue(32'h600, 5'd4, 1'b1, 2'b01, 32'h0, 32'd0, 3'b010);
        tick();
        i_in_valid = 1'b0;
        chk1("wm_ready", o_in_ready, 1'b0);
        i_rst = 1'b1;
        #1;
        chk1("wm_rst_ready", o_in_ready, 1'b0);
        chk("wm_rst_pc", o_commit_pc, 32'd0);
        tick();
        i_rst = 1'b0;
        #1;
        chk1("wm_post_rst_ready", o_in_ready, 1'b1);
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h1111_2222;
        tick();
        i_mem_rvalid = 1'b0;
        chk1("wm_rvalid_commit", o_commit, 1'b0);
        chk1("wm_rvalid_wen", o_reg_wen, 1'b0);
        chk1("wm_rvalid_ready", o_in_ready, 1'b1);
        tick();
        chk1("wm_late_commit", o_commit, 1'b0);

        // normal operation resumes
        issue(32'h700, 5'd31, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'd0, 3'd0);
        tick();
        i_in_valid = 1'b0;
        chk_write("resume", 1'b1, 5'd31, 32'hDEAD_BEEF, 32'h700);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
